// File: rtl/input_ctrl_pkg.sv
// Shared router definitions: packet geometry, route-field position and lane type.
// The output-side merge stages import the same constants so both ends agree on
// where the route field sits inside a packet.
package input_ctrl_pkg;

   localparam int unsigned PKT_WIDTH   = 57;  // packet width in bits
   localparam int unsigned PKT_SEL_LSB = 55;  // LSB of the 2-bit route field
   localparam int unsigned NUM_LANES   = 4;   // router-internal output lanes

   typedef logic [1:0] port_t;

   // One-hot lane mask for a route value.
   function automatic logic [NUM_LANES-1:0] port_onehot(input port_t p);
      return NUM_LANES'(1) << p;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO used as the ingress buffer.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   push, push_data - write one entry (ignored when full)
//   pop             - drop the head entry (ignored when empty)
//   head            - current head entry (undefined content when empty)
//   count           - occupancy, 0..DEPTH
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             do_push, do_pop;

   assign do_push = push && (count_q != FullCount);
   assign do_pop  = pop && (count_q != '0);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
         else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
      end
   end

   // Storage is not reset; stale entries are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/input_ctrl.sv
// Per-port ingress controller: buffers packets from one link and presents the
// head packet on the output lane named by its route field.
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   in_data/valid/ready  - ingress handshake
//   out_data/valid/ready - four lanes, out_valid is one-hot or zero
//   fifo_count           - FIFO occupancy, excluding the output stage
//   pkt_sent             - wrapping count of delivered packets
module input_ctrl
   import input_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH_packet = input_ctrl_pkg::PKT_WIDTH,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned SEL_LSB      = input_ctrl_pkg::PKT_SEL_LSB
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [WIDTH_packet-1:0]                in_data,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   output logic [NUM_LANES-1:0][WIDTH_packet-1:0] out_data,
   output logic [NUM_LANES-1:0]                   out_valid,
   input  logic [NUM_LANES-1:0]                   out_ready,
   output logic [$clog2(DEPTH):0]                 fifo_count,
   output logic [15:0]                            pkt_sent
);

   localparam int unsigned CntW = $clog2(DEPTH) + 1;
   localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

   typedef enum logic {StIdle, StHold} state_e;

   state_e                  state_q;
   port_t                   sel_q;
   logic [WIDTH_packet-1:0] stage_q;
   logic [15:0]             pkt_sent_q;

   logic [WIDTH_packet-1:0] fifo_head;
   logic                    push, accept, load;

   // in_ready looks only at registered occupancy, never at out_ready.
   assign in_ready = !reset && (fifo_count != FullCount);
   assign push     = in_valid && in_ready;
   assign accept   = (state_q == StHold) && out_ready[sel_q];
   // Reloading in the same cycle as an accept gives one packet per cycle.
   assign load     = ((state_q == StIdle) || accept) && (fifo_count != '0);

   sync_fifo #(
      .WIDTH (WIDTH_packet),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (in_data),
      .pop       (load),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         sel_q      <= '0;
         stage_q    <= '0;
         pkt_sent_q <= '0;
      end else begin
         if (load) begin
            stage_q <= fifo_head;
            sel_q   <= fifo_head[SEL_LSB+1:SEL_LSB];
            state_q <= StHold;
         end else if (accept) begin
            state_q <= StIdle;
         end
         if (accept) pkt_sent_q <= pkt_sent_q + 16'd1;
      end
   end

   always_comb begin
      out_valid = '0;
      out_data  = '0;
      if (state_q == StHold) begin
         out_valid        = port_onehot(sel_q);
         out_data[sel_q]  = stage_q;
      end
   end

   assign pkt_sent = pkt_sent_q;

endmodule

// File: tb/tb_input_ctrl.sv
module tb_input_ctrl;

   localparam int W     = 57;
   localparam int DEPTH = 4;

   typedef logic [W-1:0] pkt_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   pkt_t             in_data = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [3:0][W-1:0] out_data;
   logic [3:0]       out_valid;
   logic [3:0]       out_ready = 4'h0;
   logic [2:0]       fifo_count;
   logic [15:0]      pkt_sent;

   int errors = 0;
   int checks = 0;

   // Reference model: every accepted packet, oldest first, until delivered.
   pkt_t q[$];
   int   exp_sent = 0;
   logic prev_stall = 1'b0;
   logic [3:0] prev_valid;
   logic [3:0][W-1:0] prev_data;

   input_ctrl #(
      .WIDTH_packet (W),
      .DEPTH        (DEPTH),
      .SEL_LSB      (55)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .fifo_count (fifo_count),
      .pkt_sent   (pkt_sent)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic pkt_t mk_pkt(input int route);
      pkt_t p;
      p = pkt_t'({$urandom, $urandom});
      p[56:55] = 2'(route);
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard at the falling edge: inputs and outputs are stable until the next rise.
   always @(negedge clk) begin
      logic [3:0] exp_v;
      logic [3:0][W-1:0] exp_d;
      int r;
      if (reset) begin
         q.delete();
         exp_sent = 0;
         prev_stall = 1'b0;
         checks++;
         if (out_valid !== 4'h0 || out_data !== '0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mon_reset_outputs: valid=%b ready=%b, required 0", out_valid, in_ready);
         end
      end else begin
         checks++;
         if (int'(fifo_count) + (out_valid != 0 ? 1 : 0) != q.size() || fifo_count > DEPTH) begin
            errors++;
            $display("FAIL mon_occupancy: count=%0d valid=%b, required in-flight %0d",
                     fifo_count, out_valid, q.size());
         end
         checks++;
         if (in_ready !== (fifo_count < DEPTH)) begin
            errors++;
            $display("FAIL mon_in_ready: got %b with count %0d", in_ready, fifo_count);
         end
         checks++;
         if (pkt_sent !== 16'(exp_sent)) begin
            errors++;
            $display("FAIL mon_pkt_sent: got %0d, required %0d", pkt_sent, exp_sent);
         end
         if (prev_stall) begin
            checks++;
            if (out_valid !== prev_valid || out_data !== prev_data) begin
               errors++;
               $display("FAIL mon_stall_stable: valid %b->%b", prev_valid, out_valid);
            end
         end
         exp_v = 4'h0;
         exp_d = '0;
         if (out_valid != 4'h0 && q.size() > 0) begin
            r = int'(q[0][56:55]);
            exp_v[r] = 1'b1;
            exp_d[r] = q[0];
         end
         if (out_valid != 4'h0 || q.size() == 0) begin
            checks++;
            if (out_valid !== exp_v || out_data !== exp_d) begin
               errors++;
               $display("FAIL mon_lane: valid=%b data=%h, required valid=%b data=%h",
                        out_valid, out_data, exp_v, exp_d);
            end
         end
         prev_valid = out_valid;
         prev_data  = out_data;
         prev_stall = (out_valid != 4'h0) && ((out_valid & out_ready) == 4'h0);
         if ((out_valid & out_ready) != 4'h0 && q.size() > 0) begin
            void'(q.pop_front());
            exp_sent = (exp_sent + 1) % 65536;
         end
         if (in_valid && in_ready) q.push_back(in_data);
      end
   end

   task automatic drain(input string name);
      bit done = 1'b0;
      in_valid = 1'b0;
      out_ready = 4'hF;
      for (int i = 0; i < 40 && !done; i++) begin
         tick();
         done = (fifo_count == 0) && (out_valid == 4'h0);
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s_drain: count=%0d valid=%b, required empty", name, fifo_count, out_valid);
      end
      out_ready = 4'h0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if (out_valid !== 4'h0 || out_data !== '0 || in_ready !== 1'b0 ||
          fifo_count !== 3'd0 || pkt_sent !== 16'd0) begin
         errors++;
         $display("FAIL reset_state: valid=%b ready=%b count=%0d sent=%0d, required all 0",
                  out_valid, in_ready, fifo_count, pkt_sent);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b, required 1", in_ready);
      end
   endtask

   task automatic test_single();
      pkt_t p;
      p = '0;
      p[56:55] = 2'd2;
      p[19:0] = 20'h0_1234;
      out_ready = 4'h0;
      in_data = p;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 4'h0) begin
         errors++;
         $display("FAIL single_not_early: valid=%b, required 0000", out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 4'b0100 || out_data[2] !== p) begin
         errors++;
         $display("FAIL single_lane2: valid=%b data=%h, required 0100 %h", out_valid, out_data[2], p);
      end
      out_ready = 4'b0100;
      tick();
      out_ready = 4'h0;
      checks++;
      if (pkt_sent !== 16'd1 || out_valid !== 4'h0) begin
         errors++;
         $display("FAIL single_sent: sent=%0d valid=%b, required 1 0000", pkt_sent, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] base;
      base = pkt_sent;
      out_ready = 4'hF;
      for (int i = 0; i < 4; i++) begin
         in_data = mk_pkt(i);
         in_valid = 1'b1;
         tick();
         if (i >= 1) begin
            checks++;
            if (out_valid !== 4'(1 << (i - 1))) begin
               errors++;
               $display("FAIL b2b_lane_%0d: valid=%b, required %b", i - 1, out_valid, 4'(1 << (i - 1)));
            end
         end
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 4'b1000) begin
         errors++;
         $display("FAIL b2b_lane_3: valid=%b, required 1000", out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 4'h0 || fifo_count !== 3'd0 || pkt_sent !== base + 16'd4) begin
         errors++;
         $display("FAIL b2b_done: valid=%b count=%0d sent=%0d, required 0000 0 %0d",
                  out_valid, fifo_count, pkt_sent, base + 16'd4);
      end
      out_ready = 4'h0;
   endtask

   task automatic test_full();
      int accepted = 0;
      out_ready = 4'h0;
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_data = mk_pkt(int'($urandom_range(3)));
         if (in_ready) accepted++;
         tick();
         // Hold the pending packet once the buffer refuses it.
         if (accepted >= 5) break;
      end
      in_data = mk_pkt(int'($urandom_range(3)));
      tick();
      tick();
      checks++;
      if (accepted !== 5 || fifo_count !== 3'd4 || in_ready !== 1'b0 || out_valid == 4'h0) begin
         errors++;
         $display("FAIL full_stall: accepted=%0d count=%0d ready=%b, required 5 4 0",
                  accepted, fifo_count, in_ready);
      end
      out_ready = 4'hF;
      tick();
      out_ready = 4'h0;
      accepted = 0;
      for (int i = 0; i < 3; i++) begin
         if (in_ready) accepted++;
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (accepted !== 1 || fifo_count !== 3'd4) begin
         errors++;
         $display("FAIL full_one_push: pushes=%0d count=%0d, required 1 4", accepted, fifo_count);
      end
      drain("full");
   endtask

   task automatic test_wrap();
      int pushes = 0;
      logic [15:0] base;
      base = pkt_sent;
      for (int i = 0; i < 160; i++) begin
         in_data = mk_pkt(int'($urandom_range(3)));
         in_valid = ($urandom_range(3) != 0);
         out_ready = 4'($urandom);
         if (in_valid && in_ready) pushes++;
         tick();
      end
      drain("wrap");
      checks++;
      if (pushes < 10 || pkt_sent !== base + 16'(pushes)) begin
         errors++;
         $display("FAIL wrap_total: sent=%0d pushes=%0d, required %0d", pkt_sent, pushes,
                  base + 16'(pushes));
      end
   endtask

   task automatic test_hol();
      logic [15:0] base;
      pkt_t a;
      base = pkt_sent;
      a = mk_pkt(1);
      out_ready = 4'h0;
      in_data = a;
      in_valid = 1'b1;
      tick();
      in_data = mk_pkt(0);
      tick();
      in_valid = 1'b0;
      out_ready = 4'b1101;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (out_valid !== 4'b0010 || out_data[1] !== a || pkt_sent !== base) begin
            errors++;
            $display("FAIL hol_block_%0d: valid=%b sent=%0d, required 0010 %0d",
                     i, out_valid, pkt_sent, base);
         end
      end
      out_ready = 4'b0010;
      tick();
      out_ready = 4'h0;
      checks++;
      if (out_valid !== 4'b0001 || pkt_sent !== base + 16'd1) begin
         errors++;
         $display("FAIL hol_release: valid=%b sent=%0d, required 0001 %0d",
                  out_valid, pkt_sent, base + 16'd1);
      end
      drain("hol");
   endtask

   task automatic test_reset_mid();
      pkt_t p;
      out_ready = 4'h0;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = mk_pkt(int'($urandom_range(3)));
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (fifo_count !== 3'd3 || out_valid == 4'h0) begin
         errors++;
         $display("FAIL rmid_setup: count=%0d valid=%b, required 3 nonzero", fifo_count, out_valid);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 4'h0 || out_data !== '0 || in_ready !== 1'b0 ||
          fifo_count !== 3'd0 || pkt_sent !== 16'd0) begin
         errors++;
         $display("FAIL rmid_async: valid=%b ready=%b count=%0d sent=%0d, required all 0",
                  out_valid, in_ready, fifo_count, pkt_sent);
      end
      tick();
      tick();
      reset = 1'b0;
      p = mk_pkt(3);
      in_data = p;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 4'b1000 || out_data[3] !== p) begin
         errors++;
         $display("FAIL rmid_after: valid=%b data=%h, required 1000 %h", out_valid, out_data[3], p);
      end
      out_ready = 4'b1000;
      tick();
      out_ready = 4'h0;
      checks++;
      if (pkt_sent !== 16'd1 || out_valid !== 4'h0) begin
         errors++;
         $display("FAIL rmid_sent: sent=%0d valid=%b, required 1 0000", pkt_sent, out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_wrap();
      test_hol();
      test_reset_mid();
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
